// File: rtl/muldiv_seq.sv
// Iterative 32-step multiply/divide sequencer for the MIPS pipeline.
// Holds the HI/LO pair in DONE until MEM consumes it; WB cancel aborts any op.
module muldiv_seq #(
  parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF,
  parameter int          ITER    = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [1:0]  in_op,
  input  logic [31:0] in_src1,
  input  logic [31:0] in_src2,
  input  logic        cancel,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_hi,
  output logic [31:0] out_lo,
  output logic        busy
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [CW-1:0] r_cnt;
  logic          r_is_div;
  logic          r_neg_res;
  logic          r_neg_rem;
  logic          r_div0;
  logic [31:0]   r_hi;
  logic [31:0]   r_lo;
  logic [31:0]   r_b;
  logic [31:0]   r_src1;
  logic [31:0]   r_out_hi;
  logic [31:0]   r_out_lo;

  logic          w_accept;
  logic          w_last;
  logic          w_signed;
  logic          w_s1neg;
  logic          w_s2neg;
  logic [31:0]   w_abs1;
  logic [31:0]   w_abs2;
  logic [32:0]   w_sum;
  logic [32:0]   w_rem_sh;
  logic [33:0]   w_diff;
  logic          w_ge;
  logic [63:0]   w_prod;
  logic [63:0]   w_prod_fix;
  logic [31:0]   w_quo_fix;
  logic [31:0]   w_rem_fix;
  logic [31:0]   w_fix_hi;
  logic [31:0]   w_fix_lo;

  assign in_ready  = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_hi    = r_out_hi;
  assign out_lo    = r_out_lo;

  assign w_accept = (r_state == S_IDLE) && in_valid && !cancel;
  assign w_last   = (r_cnt == CW'(ITER - 1));

  // Operand conditioning: magnitudes for signed ops, sign fix-up applied in FIX.
  assign w_signed = !in_op[0];
  assign w_s1neg  = w_signed && in_src1[31];
  assign w_s2neg  = w_signed && in_src2[31];
  assign w_abs1   = w_s1neg ? (~in_src1 + 32'd1) : in_src1;
  assign w_abs2   = w_s2neg ? (~in_src2 + 32'd1) : in_src2;

  // Multiply step: {hi,lo} holds partial product above the unconsumed multiplier.
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : 33'd0);

  // Divide step: {hi,lo} is {remainder, dividend/quotient}.
  assign w_rem_sh = {r_hi, r_lo[31]};
  assign w_diff   = {1'b0, w_rem_sh} - {2'b00, r_b};
  assign w_ge     = !w_diff[33];

  assign w_prod     = {r_hi, r_lo};
  assign w_prod_fix = r_neg_res ? (~w_prod + 64'd1) : w_prod;
  assign w_quo_fix  = r_neg_res ? (~r_lo + 32'd1) : r_lo;
  assign w_rem_fix  = r_neg_rem ? (~r_hi + 32'd1) : r_hi;

  always_comb begin
    w_fix_hi = w_prod_fix[63:32];
    w_fix_lo = w_prod_fix[31:0];
    if (r_is_div) begin
      if (r_div0) begin
        w_fix_hi = r_src1;
        w_fix_lo = DIV0_LO;
      end else begin
        w_fix_hi = w_rem_fix;
        w_fix_lo = w_quo_fix;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    if (cancel) begin
      w_state_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) w_state_next = S_RUN;
        S_RUN:  if (w_last) w_state_next = S_FIX;
        S_FIX:  w_state_next = S_DONE;
        S_DONE: if (out_ready) w_state_next = S_IDLE;
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt     <= '0;
      r_is_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_b       <= '0;
      r_src1    <= '0;
      r_out_hi  <= '0;
      r_out_lo  <= '0;
    end else begin
      if (w_accept) begin
        r_cnt     <= '0;
        r_is_div  <= in_op[1];
        r_neg_res <= w_s1neg ^ w_s2neg;
        r_neg_rem <= w_s1neg;
        r_div0    <= in_op[1] && (in_src2 == 32'd0);
        r_src1    <= in_src1;
        r_hi      <= '0;
        r_lo      <= in_op[1] ? w_abs1 : w_abs2;
        r_b       <= in_op[1] ? w_abs2 : w_abs1;
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + CW'(1);
        if (r_is_div) begin
          r_hi <= w_ge ? w_diff[31:0] : w_rem_sh[31:0];
          r_lo <= {r_lo[30:0], w_ge};
        end else begin
          r_hi <= w_sum[32:1];
          r_lo <= {w_sum[0], r_lo[31:1]};
        end
      end
      // A cancel during FIX drops the result, leaving the previous outputs intact.
      if (r_state == S_FIX && !cancel) begin
        r_out_hi <= w_fix_hi;
        r_out_lo <= w_fix_lo;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: expected HI/LO pairs are queued at issue
// and popped when the sequencer presents its result.
module tb_muldiv_seq;

  logic        clk;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_src1;
  logic [31:0] in_src2;
  logic        cancel;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_hi;
  logic [31:0] out_lo;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  muldiv_seq dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_src1   (in_src1),
    .in_src2   (in_src2),
    .cancel    (cancel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_hi    (out_hi),
    .out_lo    (out_lo),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one op at a negedge while IDLE; returns at the negedge after the accept edge.
  task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                       input bit push);
    exp_t e;
    in_valid = 1'b1;
    in_op    = op;
    in_src1  = a;
    in_src2  = b;
    if (push) begin
      e.tag = tag;
      e.hi  = hi;
      e.lo  = lo;
      exp_q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
    $display("issue %s op=%0d src1=%h src2=%h", tag, op, a, b);
  endtask

  // Wait for the result, hold it for `hold` cycles, then consume it.
  task automatic collect(input int hold);
    int   n;
    bit   bad;
    exp_t e;
    n   = 0;
    bad = 1'b0;
    while (out_valid !== 1'b1 && n < 80) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) bad = 1'b1;
      @(negedge clk);
      n++;
    end
    if (exp_q.size() == 0) begin
      e.tag = "none";
      e.hi  = 'x;
      e.lo  = 'x;
    end else begin
      e = exp_q.pop_front();
    end
    chk({e.tag, "_latency"}, 64'(n), 64'd33);
    chk({e.tag, "_busy"}, 64'(bad), 64'd0);
    chk({e.tag, "_result"}, {out_hi, out_lo}, {e.hi, e.lo});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({e.tag, "_hold"}, {61'd0, out_valid, in_ready, busy}, {61'd0, 1'b1, 1'b0, 1'b1});
      chk({e.tag, "_hold_res"}, {out_hi, out_lo}, {e.hi, e.lo});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({e.tag, "_release"}, {61'd0, out_valid, in_ready, busy}, {61'd0, 1'b0, 1'b1, 1'b0});
    $display("result %s hi=%h lo=%h latency=%0d", e.tag, out_hi, out_lo, n);
  endtask

  initial begin
    bit seen;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'b00;
    in_src1   = '0;
    in_src2   = '0;
    cancel    = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl", {61'd0, in_ready, out_valid, busy}, {61'd0, 1'b1, 1'b0, 1'b0});
    chk("reset_out", {out_hi, out_lo}, 64'd0);
    resetn = 1'b1;
    @(negedge clk);

    issue("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
    collect(0);
    issue("mult_neg", OP_MULT, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1);
    collect(0);
    issue("mult_b2b", OP_MULT, 32'h7FFF_FFFF, 32'd2, 32'h0000_0000, 32'hFFFF_FFFE, 1'b1);
    collect(0);
    issue("mult_minmin", OP_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1);
    collect(0);
    issue("div_neg", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1);
    collect(0);
    issue("div_negdiv", OP_DIV, 32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b1);
    collect(0);
    issue("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
    collect(0);
    issue("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b1);
    collect(0);
    issue("divu_zero", OP_DIVU, 32'd7, 32'd0, 32'h0000_0007, 32'hFFFF_FFFF, 1'b1);
    collect(0);
    issue("div_zero", OP_DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);
    collect(0);

    // cancel 10 cycles into RUN
    issue("cancel_run", OP_MULTU, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_run_ctrl", {61'd0, in_ready, out_valid, busy}, {61'd0, 1'b1, 1'b0, 1'b0});
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    chk("cancel_no_valid", 64'(seen), 64'd0);
    chk("cancel_out_kept", {out_hi, out_lo}, {32'hFFFF_FFF9, 32'hFFFF_FFFF});
    $display("cancel in RUN done");

    // cancel in IDLE blocks the accept
    in_valid = 1'b1;
    in_op    = OP_MULTU;
    in_src1  = 32'd5;
    in_src2  = 32'd5;
    cancel   = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cancel   = 1'b0;
    chk("cancel_idle", {62'd0, in_ready, busy}, {62'd0, 1'b1, 1'b0});

    issue("multu_3x4", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 1'b1);
    collect(20);

    // cancel beats out_ready in DONE; the held result is not replaced
    issue("cancel_done", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0);
    repeat (33) @(negedge clk);
    chk("cancel_done_valid", {63'd0, out_valid}, 64'd1);
    chk("cancel_done_res", {out_hi, out_lo}, {32'd0, 32'd42});
    cancel    = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    cancel    = 1'b0;
    out_ready = 1'b0;
    chk("cancel_done_ctrl", {61'd0, in_ready, out_valid, busy}, {61'd0, 1'b1, 1'b0, 1'b0});

    // reset mid-RUN
    issue("reset_run", OP_DIVU, 32'd50, 32'd3, 32'd0, 32'd0, 1'b0);
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    chk("reset_run_ctrl", {61'd0, in_ready, out_valid, busy}, {61'd0, 1'b1, 1'b0, 1'b0});
    chk("reset_run_out", {out_hi, out_lo}, 64'd0);
    $display("reset mid-RUN done");

    issue("divu_after_rst", OP_DIVU, 32'd50, 32'd3, 32'd2, 32'd16, 1'b1);
    collect(0);

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
